onehot_rr_sched: RTL and testbench
==================================

# onehot_rr_sched

Round-robin scheduler that shares one 8-way one-hot resource (the LED/output decoder lines on `uo_out`) among eight requesters. It turns a request vector into a registered, strictly one-hot grant plus its 3-bit encoded index. The index is the select field the downstream 3-to-8 decoder consumes, and the one-hot vector drives the resource enables directly. The block sits between the `ui_in` request switches and the decoder/LED stage.

## Interface
- `MAX_HOLD`, default 15: maximum consecutive cycles one requester may hold the grant; legal range 2..255.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req` input 8: request vector; bit i high means requester i wants the resource. Level-sensitive.
- `grant` output 8: registered one-hot grant, or all-zero when idle. Never more than one bit set.
- `grant_idx` output 3: binary index of the granted bit; 0 when idle.
- `grant_vld` output 1: high when `grant` is non-zero.
- `preempt` output 1: one-cycle pulse when a grant is revoked by hold-limit expiry (see Configuration).

## Operation
- States: IDLE (no owner) and BUSY (owner = `grant_idx`).
- Pointer `last`, 3 bits: index of the most recent owner. Search order for a new winner is `last+1`, `last+2`, … wrapping modulo 8, ending at `last`.
- IDLE: if `req` is non-zero, pick the first set bit in search order. Next state is BUSY, with `grant`/`grant_idx` set to that winner, `last` set to the winner, and hold counter set to 1. If `req` is zero, stay IDLE.
- BUSY, owner still requesting, hold limit not reached: keep the grant and increment the hold counter.
- BUSY, owner drops its request: re-arbitrate in the same cycle over `req`; the owner's bit is low, so it is excluded naturally.
  - Winner found: hand over with no idle gap (new one-hot grant on the next edge).
  - No winner: go to IDLE with `grant` = 0.
- BUSY, hold counter = `MAX_HOLD` and owner still requesting (only when `ONEHOT_SCHED_HOLD_EN` is defined):
  - Arbitrate with the owner masked out.
  - If another requester wins, hand over and pulse `preempt`.
  - If no other requester exists, the owner keeps the grant, the hold counter restarts at 1, and `preempt` stays low.
- Hold counter width is `$clog2(MAX_HOLD+1)`. It saturates logically because it is reset on every grant change, so it never wraps.
- `req` bits for a non-owner may toggle freely; only the sampled value at each edge matters.
- Reset mid-operation: on the next edge the block goes to IDLE regardless of `req`.

## Timing
- Reset values:
  - `grant` = 0, `grant_idx` = 0, `grant_vld` = 0, `preempt` = 0.
  - `last` = 7, so requester 0 has first priority after reset.
  - Hold counter = 0.
- Latency: a request sampled at edge t produces its grant at edge t+1 (one-cycle registered latency).
- Release: owner `req` low at edge t means its grant is gone at t+1, and the successor's grant (if any) is present at t+1.
- Hold limit: an owner continuously requesting from grant cycle 1 holds for exactly `MAX_HOLD` cycles before handover.
- `preempt` is asserted in the same cycle the new grant first appears.
- All outputs are registered; there is no combinational path from `req` to any output.

## Configuration
- Macro: `ONEHOT_SCHED_HOLD_EN`.
- Defined: hold counter and `MAX_HOLD` preemption are active as described.
- Undefined:
  - No hold counter logic.
  - An owner keeps the grant as long as its `req` stays high.
  - `preempt` is tied to 0.
  - `MAX_HOLD` is ignored.

## Structure
- Shared package `onehot_pkg` holds:
  - `N_REQ = 8` and `IDX_W = 3`.
  - State enum `sched_state_t {S_IDLE, S_BUSY}`.
  - Function `idx2onehot` (index to one-hot), which is also used by the decoder stage.
- One sub-module: `rr_pick`. It is purely combinational. Inputs are `req`, `last`, and an exclude mask; outputs are winner index and found flag. It is instantiated once.

## Test plan
- Reset then `req`=8'h00 for 5 cycles: `grant`=0, `grant_vld`=0, `grant_idx`=0 throughout.
- After reset, `req`=8'hFF held with `ONEHOT_SCHED_HOLD_EN`, `MAX_HOLD`=3:
  - Grants go 0,0,0,1,1,1,2,… in one-hot form.
  - `preempt` pulses at each change.
  - Index wraps from 7 to 0.
- `req`=8'h24 (requesters 2 and 5), owner 2 drops `req` at cycle t: `grant`=8'h20 and `grant_idx`=5 at t+1, with no idle cycle.
- Single requester `req`=8'h08 held for 40 cycles with `MAX_HOLD`=15: `grant`=8'h08 continuously, `preempt` never asserted.
- `rst` asserted for one cycle while `grant`=8'h10: all outputs are 0 on the next edge; with `req`=8'h11 afterwards, requester 0 wins first.
- Without the macro, `req`=8'h03 held for 50 cycles: `grant`=8'h01 throughout, and `preempt`=0.

Source files
------------

// File: rtl/onehot_pkg.sv
// onehot_pkg: shared constants, scheduler state type and index decode helper
// for the one-hot round-robin scheduler and its downstream decoder stage.
package onehot_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } sched_state_t;

  function automatic logic [N_REQ-1:0] idx2onehot(
    input logic [IDX_W-1:0] idx
  );
    logic [N_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/onehot_rr_sched_rr_pick.sv
// rr_pick: combinational round-robin winner search starting after `last`,
// wrapping modulo N_REQ and ending at `last`; excluded bits never win.
module rr_pick
  import onehot_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last,
  input  logic [N_REQ-1:0] excl,
  output logic [IDX_W-1:0] win_idx,
  output logic             found
);

  logic [IDX_W-1:0] cand;

  // first eligible requester in order last+1 .. last+8
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = last + IDX_W'(k);
      if (!found && req[cand] && !excl[cand]) begin
        found   = 1'b1;
        win_idx = cand;
      end
    end
  end

endmodule

// File: rtl/onehot_rr_sched.sv
// onehot_rr_sched: registered one-hot round-robin grant for eight requesters.
// Optional hold-limit preemption is enabled by defining ONEHOT_SCHED_HOLD_EN.
module onehot_rr_sched
  import onehot_pkg::*;
#(
  parameter int MAX_HOLD = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_vld,
  output logic             preempt
);

  sched_state_t     state_q, state_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             vld_q, vld_d;
  logic             pre_q, pre_d;

  logic [N_REQ-1:0] excl;
  logic [IDX_W-1:0] win_idx;
  logic             found;
  logic             own_req;
  logic             at_lim;

  assign own_req = (state_q == S_BUSY) && req[idx_q];

`ifdef ONEHOT_SCHED_HOLD_EN
  localparam int HW = $clog2(MAX_HOLD + 1);

  logic [HW-1:0] hold_q, hold_d;

  assign at_lim = own_req && (hold_q == HW'(MAX_HOLD));
`else
  logic unused_cfg;

  assign unused_cfg = (MAX_HOLD > 255);
  assign at_lim     = 1'b0;
`endif

  // at the hold limit the current owner is kept out of the search
  assign excl = at_lim ? idx2onehot(idx_q) : '0;

  rr_pick u_pick (
    .req    (req),
    .last   (last_q),
    .excl   (excl),
    .win_idx(win_idx),
    .found  (found)
  );

  // next-state: keep, hand over, restart hold, or go idle
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    vld_d   = vld_q;
    pre_d   = 1'b0;
`ifdef ONEHOT_SCHED_HOLD_EN
    hold_d  = hold_q;
`endif
    if (own_req && !at_lim) begin
`ifdef ONEHOT_SCHED_HOLD_EN
      hold_d = hold_q + HW'(1);
`endif
    end else if (found) begin
      state_d = S_BUSY;
      last_d  = win_idx;
      idx_d   = win_idx;
      grant_d = idx2onehot(win_idx);
      vld_d   = 1'b1;
      pre_d   = at_lim;
`ifdef ONEHOT_SCHED_HOLD_EN
      hold_d  = HW'(1);
`endif
    end else if (at_lim) begin
`ifdef ONEHOT_SCHED_HOLD_EN
      hold_d = HW'(1);
`endif
    end else begin
      state_d = S_IDLE;
      grant_d = '0;
      idx_d   = '0;
      vld_d   = 1'b0;
`ifdef ONEHOT_SCHED_HOLD_EN
      hold_d  = '0;
`endif
    end
  end

  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      last_q  <= IDX_W'(N_REQ - 1);
      grant_q <= '0;
      idx_q   <= '0;
      vld_q   <= 1'b0;
      pre_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      vld_q   <= vld_d;
      pre_q   <= pre_d;
    end
  end

`ifdef ONEHOT_SCHED_HOLD_EN
  // hold counter, restarted on every grant change
  always_ff @(posedge clk) begin
    if (rst) hold_q <= '0;
    else     hold_q <= hold_d;
  end
`endif

  assign grant     = grant_q;
  assign grant_idx = idx_q;
  assign grant_vld = vld_q;
  assign preempt   = pre_q;

endmodule

// File: tb/tb_onehot_rr_sched.sv
// tb_onehot_rr_sched: directed and random stimulus against a round-robin
// reference model (owner / last / hold count) kept in the bench.
module tb_onehot_rr_sched;

  localparam int MH = 3;
`ifdef ONEHOT_SCHED_HOLD_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = 8'h00;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       grant_vld;
  logic       preempt;

  int n_cmp = 0;
  int n_bad = 0;

  int m_own  = -1;
  int m_last = 7;
  int m_hold = 0;
  bit m_pre  = 1'b0;

  always #5 clk = ~clk;

  onehot_rr_sched #(.MAX_HOLD(MH)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .grant    (grant),
    .grant_idx(grant_idx),
    .grant_vld(grant_vld),
    .preempt  (preempt)
  );

  function automatic void model_step(input logic [7:0] r, input logic rs);
    int w, ex;
    if (rs) begin
      m_own = -1; m_last = 7; m_hold = 0; m_pre = 1'b0;
      return;
    end
    m_pre = 1'b0;
    if (m_own >= 0 && r[m_own] && !(HOLD_EN && m_hold == MH)) begin
      m_hold++;
      return;
    end
    ex = (m_own >= 0 && r[m_own]) ? m_own : -1;
    w  = -1;
    for (int k = 1; k <= 8; k++) begin
      int i;
      i = (m_last + k) % 8;
      if (w < 0 && r[i] && i != ex) w = i;
    end
    if (w >= 0) begin
      m_pre  = (ex >= 0);
      m_own  = w;
      m_last = w;
      m_hold = 1;
    end else if (ex >= 0) begin
      m_hold = 1;
    end else begin
      m_own  = -1;
      m_hold = 0;
    end
  endfunction

  function automatic logic [12:0] exp_vec();
    logic [7:0] g;
    logic [2:0] ix;
    g  = (m_own < 0) ? 8'h00 : (8'h01 << m_own);
    ix = (m_own < 0) ? 3'd0 : 3'(m_own);
    return {g, ix, (m_own >= 0), m_pre};
  endfunction

  task automatic step(input logic [7:0] r, input logic rs);
    @(negedge clk);
    req = r;
    rst = rs;
    @(posedge clk);
    model_step(r, rs);
    #1;
  endtask

  task automatic test_reset();
    step(8'h00, 1'b1);
    step(8'h00, 1'b1);
    for (int c = 0; c < 5; c++) begin
      step(8'h00, 1'b0);
      n_cmp++;
      if ({grant, grant_idx, grant_vld, preempt} !== 13'h0) begin
        n_bad++;
        $display("FAIL reset_idle c%0d: got %h want 0", c,
                 {grant, grant_idx, grant_vld, preempt});
      end
    end
  endtask

  task automatic test_all_req();
    step(8'h00, 1'b1);
    for (int c = 0; c < 40; c++) begin
      step(8'hFF, 1'b0);
      n_cmp++;
      if ({grant, grant_idx, grant_vld, preempt} !== exp_vec()) begin
        n_bad++;
        $display("FAIL all_req c%0d: got %h want %h", c,
                 {grant, grant_idx, grant_vld, preempt}, exp_vec());
      end
    end
  endtask

  task automatic test_handover();
    step(8'h00, 1'b1);
    for (int c = 0; c < 2; c++) step(8'h24, 1'b0);
    n_cmp++;
    if (grant !== 8'h04 || grant_idx !== 3'd2) begin
      n_bad++;
      $display("FAIL handover_first: got %h/%0d want 04/2", grant, grant_idx);
    end
    step(8'h20, 1'b0);
    n_cmp++;
    if ({grant, grant_idx, grant_vld, preempt} !== {8'h20, 3'd5, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL handover_gap: got %h/%0d vld %b want 20/5 vld 1",
               grant, grant_idx, grant_vld);
    end
    step(8'h00, 1'b0);
    n_cmp++;
    if ({grant, grant_idx, grant_vld} !== 12'h0) begin
      n_bad++;
      $display("FAIL handover_idle: got %h want 0", {grant, grant_idx, grant_vld});
    end
  endtask

  task automatic test_single();
    step(8'h00, 1'b1);
    for (int c = 0; c < 40; c++) begin
      step(8'h08, 1'b0);
      n_cmp++;
      if (grant !== 8'h08 || preempt !== 1'b0 || grant_idx !== 3'd3) begin
        n_bad++;
        $display("FAIL single c%0d: got %h pre %b want 08 pre 0", c, grant, preempt);
      end
    end
  endtask

  task automatic test_reset_mid();
    step(8'h00, 1'b1);
    step(8'h10, 1'b0);
    n_cmp++;
    if (grant !== 8'h10) begin
      n_bad++;
      $display("FAIL rmid_setup: got %h want 10", grant);
    end
    step(8'h10, 1'b1);
    n_cmp++;
    if ({grant, grant_idx, grant_vld, preempt} !== 13'h0) begin
      n_bad++;
      $display("FAIL rmid_zero: got %h want 0", {grant, grant_idx, grant_vld, preempt});
    end
    step(8'h11, 1'b0);
    n_cmp++;
    if (grant !== 8'h01 || grant_idx !== 3'd0) begin
      n_bad++;
      $display("FAIL rmid_prio: got %h/%0d want 01/0", grant, grant_idx);
    end
  endtask

  task automatic test_two_held();
    step(8'h00, 1'b1);
    for (int c = 0; c < 50; c++) begin
      step(8'h03, 1'b0);
      n_cmp++;
      if ({grant, grant_idx, grant_vld, preempt} !== exp_vec()) begin
        n_bad++;
        $display("FAIL two_held c%0d: got %h want %h", c,
                 {grant, grant_idx, grant_vld, preempt}, exp_vec());
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] r;
    logic       rs;
    r = 8'h00;
    step(8'h00, 1'b1);
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 4) == 0) r = 8'($urandom) & 8'($urandom);
      if ($urandom_range(0, 9) == 0) r[$urandom_range(0, 7)] ^= 1'b1;
      rs = ($urandom_range(0, 59) == 0);
      step(r, rs);
      n_cmp++;
      if ({grant, grant_idx, grant_vld, preempt} !== exp_vec()) begin
        n_bad++;
        $display("FAIL random c%0d req %h: got %h want %h", c, r,
                 {grant, grant_idx, grant_vld, preempt}, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_all_req();
    test_handover();
    test_single();
    test_reset_mid();
    test_two_held();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
